// File: rtl/aska_npg_pkg.sv
// ASKA neuro-stimulation pulse generator: shared types and widths.
// Imported by the core and the amplitude ramp unit.
package aska_npg_pkg;

  localparam int AMP_W  = 6;
  localparam int N_ELEC = 4;
  localparam int FRAC_W = 4;
  localparam int ACC_W  = 12;
  localparam int FREQ_W = 12;
  localparam int PD_W   = 3;
  localparam int RAMP_W = 6;
  localparam int RF_W   = 10;
  localparam int ON_W   = 8;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } npg_state_e;

  function automatic logic sel_unsafe(
    input logic [N_ELEC-1:0] a,
    input logic [N_ELEC-1:0] b
  );
    return (|(a & b)) | ~(|a) | ~(|b);
  endfunction

endpackage

// File: rtl/aska_npg_ramp.sv
// Per-pulse amplitude: saturating 6.4 fixed-point ramp-up accumulator.
// Build option RAMP_DOWN_EN mirrors the ramp at the end of each ON burst.
module aska_npg_ramp
  import aska_npg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [AMP_W-1:0]  amplitude_i,
  input  logic [RF_W-1:0]   ramp_factor_i,
  input  logic [RAMP_W-1:0] ramp_i,
  input  logic [CNT_W-1:0]  k_i,
  input  logic [ON_W-1:0]   on_time_i,
  output logic [AMP_W-1:0]  amp_now_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] lim;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;

  logic [ACC_W-FRAC_W-1:0] acc_hi;
  logic [AMP_W-1:0]        up_min;
  logic [AMP_W-1:0]        amp_up;
  logic                    in_up;

  assign lim = {{(ACC_W-AMP_W-FRAC_W){1'b0}},
                amplitude_i,
                {FRAC_W{1'b0}}};

  // A new burst restarts from zero so pulse 0 gets one step.
  assign base    = start_i ? '0 : acc_q;
  assign sum     = {1'b0, base} + (ACC_W+1)'(ramp_factor_i);
  assign acc_nxt = (sum > {1'b0, lim}) ? lim : sum[ACC_W-1:0];

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (start_i || step_i) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_hi = acc_q[ACC_W-1:FRAC_W];
  assign up_min = (acc_hi > (ACC_W-FRAC_W)'(amplitude_i))
                ? amplitude_i
                : acc_hi[AMP_W-1:0];
  assign in_up  = (ramp_i != '0) &&
                  (k_i < CNT_W'(ramp_i));
  assign amp_up = in_up ? up_min : amplitude_i;

`ifdef RAMP_DOWN_EN
  logic [CNT_W-1:0]    rem;
  logic [2*RF_W-1:0]   dn_prod;
  logic [2*RF_W-5:0]   dn_hi;
  logic [AMP_W-1:0]    dn_min;
  logic                in_dn;
  logic                unused_dn;

  assign rem     = CNT_W'(on_time_i) - k_i;
  assign dn_prod = (2*RF_W)'(rem) * (2*RF_W)'(ramp_factor_i);
  assign dn_hi   = dn_prod[2*RF_W-1:FRAC_W];
  assign dn_min  = (dn_hi > (2*RF_W-4)'(amplitude_i))
                 ? amplitude_i
                 : dn_hi[AMP_W-1:0];
  assign in_dn   = (ramp_i != '0) &&
                   (k_i < CNT_W'(on_time_i)) &&
                   ((k_i + CNT_W'(ramp_i)) >= CNT_W'(on_time_i));
  assign unused_dn = ^dn_prod[FRAC_W-1:0];

  // Overlapping ramps take the lower of the two envelopes.
  assign amp_now_o = (in_dn && (dn_min < amp_up)) ? dn_min : amp_up;
`else
  logic unused_dn;
  assign unused_dn = ^on_time_i;
  assign amp_now_o = amp_up;
`endif

endmodule

// File: rtl/aska_npg_core.sv
// ASKA biphasic pulse generator: IDLE/ON/OFF burst sequencer,
// period/pulse counters and Moore decode of switches and DAC code.
module aska_npg_core
  import aska_npg_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic [FREQ_W-1:0] freq,
  input  logic [PD_W-1:0]   phaseDuration,
  input  logic [RAMP_W-1:0] ramp,
  input  logic [RF_W-1:0]   ramp_factor,
  input  logic [ON_W-1:0]   ON_time,
  input  logic [CNT_W-1:0]  OFF_time,
  input  logic [N_ELEC-1:0] electrode1,
  input  logic [N_ELEC-1:0] electrode2,
  input  logic              enable,
  output logic [N_ELEC-1:0] up_switches,
  output logic [N_ELEC-1:0] down_switches,
  output logic [AMP_W-1:0]  DAC
);

  npg_state_e        state_q;
  npg_state_e        state_d;
  logic [FREQ_W-1:0] pc_q;
  logic [FREQ_W-1:0] pc_d;
  logic [CNT_W-1:0]  k_q;
  logic [CNT_W-1:0]  k_d;

  logic [FREQ_W-1:0] pd_x;
  logic [FREQ_W-1:0] min_per;
  logic [FREQ_W-1:0] per;
  logic [FREQ_W-1:0] per_m1;
  logic              wrap;
  logic [CNT_W:0]    k_inc;
  logic              on_done;
  logic              off_done;

  logic              r_clr;
  logic              r_start;
  logic              r_step;
  logic [AMP_W-1:0]  amp_now;

  // The period always fits both phases, the gap and one idle slot.
  assign pd_x    = FREQ_W'(phaseDuration);
  assign min_per = (pd_x << 1) + FREQ_W'(2);
  assign per     = (freq > min_per) ? freq : min_per;
  assign per_m1  = per - FREQ_W'(1);
  assign wrap    = (pc_q >= per_m1);

  assign k_inc    = {1'b0, k_q} + (CNT_W+1)'(1);
  assign on_done  = (k_inc >= (CNT_W+1)'(ON_time));
  assign off_done = (k_inc >= (CNT_W+1)'(OFF_time));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    k_d     = k_q;
    r_clr   = 1'b0;
    r_start = 1'b0;
    r_step  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      pc_d    = '0;
      k_d     = '0;
      r_clr   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_d = '0;
          k_d  = '0;
          if (ON_time == '0) begin
            state_d = OFF;
          end else begin
            state_d = ON;
            r_start = 1'b1;
          end
        end
        ON: begin
          if (wrap) begin
            pc_d = '0;
            if (on_done) begin
              k_d = '0;
              if (OFF_time == '0) begin
                r_start = 1'b1;
              end else begin
                state_d = OFF;
              end
            end else begin
              k_d    = k_inc[CNT_W-1:0];
              r_step = 1'b1;
            end
          end else begin
            pc_d = pc_q + FREQ_W'(1);
          end
        end
        OFF: begin
          if (wrap) begin
            pc_d = '0;
            if (off_done) begin
              k_d = '0;
              if (ON_time != '0) begin
                state_d = ON;
                r_start = 1'b1;
              end
            end else begin
              k_d = k_inc[CNT_W-1:0];
            end
          end else begin
            pc_d = pc_q + FREQ_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          pc_d    = '0;
          k_d     = '0;
          r_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
    end
  end

  aska_npg_ramp u_ramp (
    .clk           (clk),
    .rst_n         (resetn),
    .clr_i         (r_clr),
    .start_i       (r_start),
    .step_i        (r_step),
    .amplitude_i   (amplitude),
    .ramp_factor_i (ramp_factor),
    .ramp_i        (ramp),
    .k_i           (k_q),
    .on_time_i     (ON_time),
    .amp_now_o     (amp_now)
  );

  logic active;
  logic phase_a;
  logic phase_b;

  assign active  = (state_q == ON) &&
                   !sel_unsafe(electrode1, electrode2);
  assign phase_a = (pc_q < pd_x);
  assign phase_b = (pc_q > pd_x) && (pc_q <= (pd_x << 1));

  always_comb begin
    up_switches   = '0;
    down_switches = '0;
    DAC           = '0;
    if (active) begin
      unique case (1'b1)
        phase_a: begin
          up_switches   = electrode1;
          down_switches = electrode2;
          DAC           = amp_now;
        end
        phase_b: begin
          up_switches   = electrode2;
          down_switches = electrode1;
          DAC           = amp_now;
        end
        default: begin
          up_switches   = '0;
          down_switches = '0;
          DAC           = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aska_npg_core.sv
// Bench for aska_npg_core: cycle-accurate reference from burst arithmetic
// plus hand-computed spot values.
module tb_aska_npg_core;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] amplitude;
  logic [11:0] freq;
  logic [2:0] phaseDuration;
  logic [5:0] ramp;
  logic [9:0] ramp_factor;
  logic [7:0] ON_time;
  logic [9:0] OFF_time;
  logic [3:0] electrode1;
  logic [3:0] electrode2;
  logic       enable = 1'b0;
  logic [3:0] up_switches;
  logic [3:0] down_switches;
  logic [5:0] DAC;

  int n_cmp = 0;
  int n_bad = 0;
  int n_prn = 0;
  int mt = -1;

  aska_npg_core dut (
    .clk           (clk),
    .resetn        (resetn),
    .amplitude     (amplitude),
    .freq          (freq),
    .phaseDuration (phaseDuration),
    .ramp          (ramp),
    .ramp_factor   (ramp_factor),
    .ON_time       (ON_time),
    .OFF_time      (OFF_time),
    .electrode1    (electrode1),
    .electrode2    (electrode2),
    .enable        (enable),
    .up_switches   (up_switches),
    .down_switches (down_switches),
    .DAC           (DAC)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since the edge that started the run (-1 = idle).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mt <= -1;
    else if (!enable) mt <= -1;
    else mt <= mt + 1;
  end

  function automatic logic [13:0] model(input int t);
    int pd, p, on, off, rp, rf, l, pos, k, pc, a, d;
    logic [3:0] u, dn;
    pd = phaseDuration; on = ON_time; off = OFF_time;
    rp = ramp; rf = ramp_factor;
    u = '0; dn = '0;
    if (t < 0 || on == 0) return '0;
    p = freq;
    if (p < 2*pd + 2) p = 2*pd + 2;
    l = (on + off) * p;
    pos = t % l;
    if (pos >= on * p) return '0;
    if ((electrode1 & electrode2) != 0 ||
        electrode1 == 0 || electrode2 == 0) return '0;
    k = pos / p;
    pc = pos % p;
    a = amplitude;
    if (rp != 0 && k < rp) begin
      d = ((k + 1) * rf) >> 4;
      if (d < a) a = d;
    end
`ifdef RAMP_DOWN_EN
    if (rp != 0 && k >= on - rp) begin
      d = ((on - k) * rf) >> 4;
      if (d < a) a = d;
    end
`endif
    if (pc < pd) begin
      u = electrode1; dn = electrode2;
    end else if (pc > pd && pc < 2*pd + 1) begin
      u = electrode2; dn = electrode1;
    end else begin
      a = 0;
    end
    return {u, dn, 6'(a)};
  endfunction

  logic [13:0] exp_v;
  always @(negedge clk) begin
    exp_v = model(mt);
    n_cmp++;
    if ({up_switches, down_switches, DAC} !== exp_v) begin
      n_bad++;
      if (n_prn < 20) begin
        n_prn++;
        $display("FAIL model t=%0d: up/down/dac got %b/%b/%0d want %b/%b/%0d",
                 mt, up_switches, down_switches, DAC,
                 exp_v[13:10], exp_v[9:6], exp_v[5:0]);
      end
    end
  end

  task automatic lit(input string nm, input logic [13:0] want);
    n_cmp++;
    if ({up_switches, down_switches, DAC} !== want) begin
      n_bad++;
      $display("FAIL %s: up/down/dac got %b/%b/%0d want %b/%b/%0d",
               nm, up_switches, down_switches, DAC,
               want[13:10], want[9:6], want[5:0]);
    end
  endtask

  task automatic adv_to(input int target);
    int g = 0;
    while (mt != target && g < 100000) begin
      @(negedge clk);
      g++;
    end
    if (mt != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: t=%0d want %0d", mt, target);
    end
  endtask

  task automatic stop_run();
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    amplitude = 6'd10; freq = 12'd400; phaseDuration = 3'd4;
    ramp = 6'd10; ramp_factor = 10'd16;
    ON_time = 8'd50; OFF_time = 10'd50;
    electrode1 = 4'b0100; electrode2 = 4'b0001;
    repeat (3) @(negedge clk);
    lit("reset", 14'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1 enable = 1'b1;

    adv_to(0);     lit("t0_phaseA", {4'b0100, 4'b0001, 6'd1});
    adv_to(4);     lit("t4_gap", 14'd0);
    adv_to(5);     lit("t5_phaseB", {4'b0001, 4'b0100, 6'd1});
    adv_to(9);     lit("t9_off", 14'd0);
    adv_to(400);   lit("k1", {4'b0100, 4'b0001, 6'd2});
    adv_to(3600);  lit("k9", {4'b0100, 4'b0001, 6'd10});
    adv_to(4000);  lit("k10", {4'b0100, 4'b0001, 6'd10});
    adv_to(20000); lit("burst_off", 14'd0);
    adv_to(40000); lit("burst2_k0", {4'b0100, 4'b0001, 6'd1});

    adv_to(40001);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk); lit("before_stop", {4'b0100, 4'b0001, 6'd1});
    @(negedge clk); lit("stopped", 14'd0);

    ramp = 6'd0;
    @(posedge clk); #1 enable = 1'b1;
    adv_to(0);   lit("noramp_k0", {4'b0100, 4'b0001, 6'd10});
    adv_to(805); lit("noramp_k2B", {4'b0001, 4'b0100, 6'd10});

    stop_run();
    ramp = 6'd10; ramp_factor = 10'd200; enable = 1'b1;
    adv_to(0);   lit("sat_k0", {4'b0100, 4'b0001, 6'd10});
    adv_to(1000);

    stop_run();
    electrode1 = 4'b0010; electrode2 = 4'b0010; enable = 1'b1;
    adv_to(0);   lit("same_elec", 14'd0);
    adv_to(800);

    stop_run();
    electrode1 = 4'b0100; electrode2 = 4'b0001;
    phaseDuration = 3'd0; enable = 1'b1;
    adv_to(0);   lit("pd0", 14'd0);
    adv_to(800);

    stop_run();
    phaseDuration = 3'd4; freq = 12'd5; ramp = 6'd0; enable = 1'b1;
    adv_to(10);  lit("p10_A", {4'b0100, 4'b0001, 6'd10});
    adv_to(15);  lit("p10_B", {4'b0001, 4'b0100, 6'd10});
    adv_to(19);  lit("p10_idle", 14'd0);
    adv_to(53);  lit("pre_reset", {4'b0100, 4'b0001, 6'd10});
    #2 resetn = 1'b0;
    #1 lit("async_reset", 14'd0);
    @(posedge clk); #1 enable = 1'b0; resetn = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
